md_issue_ctrl: RTL

- Sits directly upstream of the multiply/divide core in the M stage.
- Decodes MULT/MULTU/DIV/DIVU/MTHI/MTLO requests and holds the architectural HI/LO registers.
- Issues operands to the core over a valid/ready handshake and commits core results to HI/LO.
- Drives the pipeline stall (busy) and enforces the architectural minimum latency: 5 cycles for multiply, 10 for divide.

---
 rtl/md_issue_ctrl.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/md_issue_ctrl.sv
// md_issue_ctrl: multiply/divide issue controller for the M stage.
// Decodes MULT/MULTU/DIV/DIVU/MTHI/MTLO, owns HI/LO, hands operands to the
// mul/div core over valid/ready and holds busy for at least the architectural
// latency (MUL_CYCLES / DIV_CYCLES) or until the core finishes, whichever is later.
module md_issue_ctrl #(
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [2:0]  req_op,
  input  logic        req_kill,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        req_ready,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        core_in_valid,
  input  logic        core_in_ready,
  output logic [31:0] core_src0,
  output logic [31:0] core_src1,
  output logic [1:0]  core_op,
  output logic        core_sign,
  input  logic        core_out_valid,
  output logic        core_out_ready,
  input  logic [31:0] core_res0,
  input  logic [31:0] core_res1
);

  localparam int unsigned MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int unsigned CW   = $clog2(MAXC);
  localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES - 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;
  logic [31:0]   src0_q, src0_d;
  logic [31:0]   src1_q, src1_d;
  logic [1:0]    op_q, op_d;
  logic          sign_q, sign_d;
  logic          accept;
  logic          out_rdy;

  assign accept  = req_valid & ~req_kill & (state_q == S_IDLE);
  assign out_rdy = (state_q == S_WAIT) && (cnt_q == '0);

  assign busy           = (state_q != S_IDLE);
  assign req_ready      = ~busy;
  assign core_in_valid  = (state_q == S_ISSUE);
  assign core_out_ready = out_rdy;
  assign hi             = hi_q;
  assign lo             = lo_q;
  assign core_src0      = src0_q;
  assign core_src1      = src1_q;
  assign core_op        = op_q;
  assign core_sign      = sign_q;

  // Next-state: decode on acceptance, issue handshake, minimum-latency countdown and commit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    src0_d  = src0_q;
    src1_d  = src1_q;
    op_d    = op_q;
    sign_d  = sign_q;

    if ((state_q != S_IDLE) && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          unique case (req_op)
            OP_MULT, OP_MULTU: begin
              src0_d  = rs_val;
              src1_d  = rt_val;
              op_d    = 2'b01;
              sign_d  = (req_op == OP_MULT);
              cnt_d   = MUL_LOAD;
              state_d = S_ISSUE;
            end
            OP_DIV, OP_DIVU: begin
              // Divide by zero is architecturally undefined: drop it, leave HI/LO alone.
              if (rt_val != '0) begin
                src0_d  = rs_val;
                src1_d  = rt_val;
                op_d    = 2'b10;
                sign_d  = (req_op == OP_DIV);
                cnt_d   = DIV_LOAD;
                state_d = S_ISSUE;
              end
            end
            OP_MTHI: hi_d = rs_val;
            OP_MTLO: lo_d = rs_val;
            default: ;
          endcase
        end
      end
      S_ISSUE: begin
        if (core_in_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (core_out_valid && out_rdy) begin
          lo_d    = core_res0;
          hi_d    = core_res1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      src0_q  <= '0;
      src1_q  <= '0;
      op_q    <= '0;
      sign_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      src0_q  <= src0_d;
      src1_q  <= src1_d;
      op_q    <= op_d;
      sign_q  <= sign_d;
    end
  end

endmodule
